// File: rtl/sum_block_accumulator.sv
// Purpose: sums every N valid adder results into a block sum and queues block sums in a small FIFO.
// Latency: the block sum enters the FIFO on the edge that accepts the Nth result, so it is visible the cycle after that edge.
// Backpressure: out_valid/out_ready on the output; input has none, so sums arriving at a full FIFO are dropped and flagged sticky.
module sum_block_accumulator #(
    parameter int W     = 16,
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         in_valid,
    input  logic [W-1:0]                 in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W+$clog2(N)-1:0]       out_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [$clog2(N)-1:0]         phase,
    output logic                         dropped
);

    localparam int OW = W + $clog2(N);
    localparam int PW = $clog2(N);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] PHASE_LAST = PW'(N - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    // Accumulator state
    logic [OW-1:0] acc_q, acc_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          dropped_q, dropped_d;

    // FIFO state
    logic [OW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    logic          in_acc;
    logic [OW-1:0] in_ext;
    logic [OW-1:0] sum;
    logic          push;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          drop;

    // Outputs come straight from FIFO registers: no path from in_* to out_*.
    assign out_valid = (level_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign level     = level_q;
    assign phase     = phase_q;
    assign dropped   = dropped_q;

    // Handshake decode; a simultaneous pop frees the slot a full-FIFO push needs.
    always_comb begin
        in_acc  = in_valid && !clr;
        in_ext  = {{(OW-W){1'b0}}, in_data};
        sum     = ((phase_q == '0) ? '0 : acc_q) + in_ext;
        push    = in_acc && (phase_q == PHASE_LAST);
        pop     = out_valid && out_ready;
        full    = (level_q == LEVEL_FULL);
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;
    end

    // Next-state for the block accumulator and sticky drop flag.
    always_comb begin
        acc_d     = acc_q;
        phase_d   = phase_q;
        dropped_d = dropped_q;
        if (clr) begin
            acc_d     = '0;
            phase_d   = '0;
            dropped_d = 1'b0;
        end else begin
            if (in_acc) begin
                acc_d   = sum;
                phase_d = push ? '0 : phase_q + PW'(1);
            end
            if (drop) begin
                dropped_d = 1'b1;
            end
        end
    end

    // Next-state for FIFO pointers and occupancy; clr leaves the FIFO alone.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Register update; rst overrides everything including an in-flight block or drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            phase_q   <= '0;
            dropped_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            acc_q     <= acc_d;
            phase_q   <= phase_d;
            dropped_q <= dropped_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= sum;
            end
        end
    end

endmodule

// File: tb/tb_sum_block_accumulator.sv
// Directed bench for sum_block_accumulator with W=16, N=4, DEPTH=4.
// Inputs change 1 ns after posedge; outputs are checked at that same point.
module tb_sum_block_accumulator;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;
    logic [2:0]  level;
    logic [1:0]  phase;
    logic        dropped;

    int checks;
    int failures;

    sum_block_accumulator #(.W(16), .N(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .phase     (phase),
        .dropped   (dropped)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
        checks++; if (out_data !== 18'h0) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (phase !== 2'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", phase); end
        checks++; if (dropped !== 1'b0) begin failures++; $display("FAIL reset_dropped got=%0h exp=0", dropped); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        step(16'd1);
        step(16'd2);
        step(16'd3);
        checks++; if (phase !== 2'd3) begin failures++; $display("FAIL basic_phase3 got=%0d exp=3", phase); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0h exp=0", out_valid); end
        step(16'd4);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0h exp=1", out_valid); end
        checks++; if (out_data !== 18'd10) begin failures++; $display("FAIL basic_data got=%0d exp=10", out_data); end
        checks++; if (phase !== 2'd0) begin failures++; $display("FAIL basic_phase_wrap got=%0d exp=0", phase); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse_end got=%0h exp=0", out_valid); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL basic_level got=%0d exp=0", level); end
    endtask

    task automatic test_wide_gaps();
        logic [1:0] exp_phase;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < i; g++) tick();
            if (i > 0) begin
                exp_phase = 2'(i);
                checks++; if (phase !== exp_phase) begin failures++; $display("FAIL gap_hold_phase got=%0d exp=%0d", phase, exp_phase); end
            end
            step(16'hFFFF);
            exp_phase = 2'((i + 1) % 4);
            checks++; if (phase !== exp_phase) begin failures++; $display("FAIL wide_phase got=%0d exp=%0d", phase, exp_phase); end
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL wide_valid got=%0h exp=1", out_valid); end
        checks++; if (out_data !== 18'h3FFFC) begin failures++; $display("FAIL wide_data got=%0h exp=3fffc", out_data); end
        tick();
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL wide_level got=%0d exp=0", level); end
    endtask

    task automatic test_full_drop();
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step(16'(k));
            step(16'd0);
            step(16'd0);
            step(16'd0);
            if (k == 4) begin
                checks++; if (dropped !== 1'b0) begin failures++; $display("FAIL full_no_drop_yet got=%0h exp=0", dropped); end
            end
        end
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", level); end
        checks++; if (dropped !== 1'b1) begin failures++; $display("FAIL full_dropped got=%0h exp=1", dropped); end
        checks++; if (phase !== 2'd0) begin failures++; $display("FAIL full_phase got=%0d exp=0", phase); end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 18'(i)) begin failures++; $display("FAIL drain_data got=%0d/%0h exp=%0d/1", out_data, out_valid, i); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL drain_level got=%0d exp=0", level); end
        checks++; if (dropped !== 1'b1) begin failures++; $display("FAIL drain_dropped_sticky got=%0h exp=1", dropped); end
    endtask

    task automatic test_clear();
        out_ready = 1'b0;
        step(16'd7);
        step(16'd7);
        checks++; if (phase !== 2'd2) begin failures++; $display("FAIL clr_pre_phase got=%0d exp=2", phase); end
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd100;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        checks++; if (phase !== 2'd0) begin failures++; $display("FAIL clr_phase got=%0d exp=0", phase); end
        checks++; if (dropped !== 1'b0) begin failures++; $display("FAIL clr_dropped got=%0h exp=0", dropped); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL clr_level got=%0d exp=0", level); end
        out_ready = 1'b1;
        step(16'd5);
        step(16'd5);
        step(16'd5);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_early_valid got=%0h exp=0", out_valid); end
        step(16'd5);
        checks++; if (out_valid !== 1'b1 || out_data !== 18'd20) begin failures++; $display("FAIL clr_sum got=%0d/%0h exp=20/1", out_data, out_valid); end
        tick();
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL clr_single_output got=%0d exp=0", level); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [17:0] exp_q [4];
        exp_q[0] = 18'd12;
        exp_q[1] = 18'd13;
        exp_q[2] = 18'd14;
        exp_q[3] = 18'd36;
        out_ready = 1'b0;
        for (int k = 11; k <= 14; k++) begin
            step(16'(k));
            step(16'd0);
            step(16'd0);
            step(16'd0);
        end
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL pp_fill_level got=%0d exp=4", level); end
        step(16'd9);
        step(16'd9);
        step(16'd9);
        out_ready = 1'b1;
        step(16'd9);
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL pp_level got=%0d exp=4", level); end
        checks++; if (dropped !== 1'b0) begin failures++; $display("FAIL pp_dropped got=%0h exp=0", dropped); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin failures++; $display("FAIL pp_drain got=%0d/%0h exp=%0d/1", out_data, out_valid, exp_q[i]); end
            tick();
        end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL pp_end_level got=%0d exp=0", level); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(16'd1);
            step(16'd0);
            step(16'd0);
            step(16'd0);
        end
        step(16'd2);
        step(16'd2);
        checks++; if (level !== 3'd3 || phase !== 2'd2) begin failures++; $display("FAIL rm_pre got=%0d/%0d exp=3/2", level, phase); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_out_valid got=%0h exp=0", out_valid); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL rm_level got=%0d exp=0", level); end
        checks++; if (phase !== 2'd0) begin failures++; $display("FAIL rm_phase got=%0d exp=0", phase); end
        out_ready = 1'b1;
        step(16'd1);
        step(16'd1);
        step(16'd1);
        step(16'd1);
        checks++; if (out_valid !== 1'b1 || out_data !== 18'd4) begin failures++; $display("FAIL rm_sum got=%0d/%0h exp=4/1", out_data, out_valid); end
        tick();
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL rm_end_level got=%0d exp=0", level); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'd0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_wide_gaps();
        test_full_drop();
        test_clear();
        test_full_push_pop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
